pixel_line_capture: RTL and testbench
=====================================

# pixel_line_capture

Upstream stage of the pupil detector. Assembles the inward-camera 8-bit grayscale pixel stream into packed full-width lines, ping-pong buffered across two banks. Presents each completed line with a valid/ack handshake and line index. Raises `frame_capture_done` once every line of the frame has been delivered or discarded.

## Interface
- `MAX_RESOLUTION`, 112: pixels per line.
- `NUM_LINES`, 112: lines per frame.
- `PIXEL_W`, 8: bits per pixel; black = 0, white = 255.

Ports:
- `clock` in 1: single clock domain; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `frame_start` in 1: one-cycle pulse that begins a frame.
- `pixel_valid` in 1: `pixel_data` is valid this cycle.
- `pixel_data` in `PIXEL_W`: grayscale pixel.
- `line_out` out `MAX_RESOLUTION*PIXEL_W`: packed line; pixel k occupies bits [8k+7:8k], where pixel 0 is the first received.
- `line_valid` out 1: `line_out` and `line_index` hold a complete line.
- `line_ack` in 1: consumer accepts the line. A transfer occurs when `line_valid` and `line_ack` are both 1.
- `line_index` out 8: row number of the line on `line_out`, range 0..`NUM_LINES`-1.
- `frame_capture_done` out 1: level signal; high from frame completion until the next `frame_start`.
- `overflow` out 1: sticky; set when any line is discarded; cleared by `frame_start`.

## Operation
- Reset values: `line_out`=0, `line_valid`=0, `line_index`=0, `frame_capture_done`=0, `overflow`=0. Write FSM enters IDLE and both banks are empty.
- Write FSM states:
  - IDLE: `pixel_valid` is ignored. `frame_start` → FILL, pixel_cnt=0, row_cnt=0.
  - FILL: each valid pixel is written to the write bank at pixel_cnt, then pixel_cnt++.
    - On pixel `MAX_RESOLUTION`-1: the bank is marked full with tag row_cnt; row_cnt++; pixel_cnt=0.
    - If the other bank is empty, it becomes the write bank and the FSM stays in FILL.
    - If the other bank is not empty → DISCARD.
  - DISCARD: valid pixels are counted but not stored; `overflow` is set at entry.
    - At the line boundary: row_cnt++ (the dropped row is skipped, so the next row keeps its correct index).
    - Then → FILL if a bank is free at that cycle; otherwise stay in DISCARD for the next line.
  - From FILL or DISCARD: when row_cnt reaches `NUM_LINES` → DONE.
  - DONE: pixels are ignored and `overflow` is not set. `frame_capture_done` rises once both banks are empty.
- Read side is a 2-entry in-order queue of full banks:
  - The head bank drives `line_out` and `line_index`.
  - A transfer frees the head bank. If the second bank is full, it is presented on the next cycle.
- `frame_start` in any state other than IDLE aborts the frame:
  - Both banks emptied, `line_valid`→0, `frame_capture_done`→0, `overflow`→0, counters→0.
  - State → FILL.
  - A pixel in the same cycle as `frame_start` is stored as pixel 0 of row 0.
- Asserting `reset` mid-line discards all state immediately.
- Widths: pixel_cnt and row_cnt are 8-bit and never wrap, because both limits are ≤ 128.

## Timing
- The last pixel of a line is written at edge N. `line_valid`=1 after edge N+1 if no line is pending; otherwise it follows the pending transfer.
- `line_out` and `line_index` are stable while `line_valid`=1. `line_valid` never drops without a transfer, except on `frame_start` or reset.
- Back-to-back transfers: `line_ack` held at 1 drains two full banks in 2 consecutive cycles.
- A bank freed by a transfer at edge T is writable by a pixel arriving at edge T+1. A freed bank is not writable on the same edge that frees it.
- `frame_capture_done` rises 1 cycle after the final transfer, or 1 cycle after entry to DONE if both banks are already empty.
- Throughput: one pixel per cycle is sustained, provided each line is acknowledged within `MAX_RESOLUTION` cycles of its presentation.

## Structure
- Shared package holds `MAX_RESOLUTION`, `PIXEL_W`, the line width `MAX_RESOLUTION*PIXEL_W`, and the write-FSM state encodings (IDLE, FILL, DISCARD, DONE). The pupil detector uses the same package.
- Sub-module `line_bank`: one `MAX_RESOLUTION`×`PIXEL_W` register with a write enable and write index, a packed read output, and full flag and row tag. It is instantiated twice.
- The top level contains the write FSM, the bank-select and queue logic, and the output muxing.

## Test plan
1. Reset, then `frame_start`, then 112 pixels with values 0..111 and `line_ack` tied to 1 → `line_valid` for 1 cycle; `line_out`[7:0]=0; `line_out`[895:888]=111; `line_index`=0.
2. Full 112×112 frame, continuous pixels, `line_ack`=1 → 112 transfers with indices 0..111 in order; `frame_capture_done`=1 one cycle after the last transfer; `overflow`=0.
3. `line_ack` held at 0 for the first 3 lines → rows 0 and 1 are buffered, row 2 is discarded, `overflow`=1. After acking, rows 0, 1, 3 are delivered with indices 0, 1, 3.
4. Both banks full, then `line_ack` pulsed for 1 cycle → row 0 is transferred; row 1 is presented on the next cycle; the freed bank accepts the pixel arriving 2 cycles after the transfer.
5. `frame_start` at pixel 50 of row 5, with a line pending → `line_valid`=0 on the next cycle; the new frame's row 0 has `line_index`=0; `overflow`=0.
6. `reset` driven low asynchronously mid-line with `line_valid`=1 → all outputs return to 0 without a clock edge; pixels are ignored until the next `frame_start`.

Source files
------------

// File: rtl/pixel_line_capture_pkg.sv
// rtl/pixel_line_capture_pkg.sv - line geometry and write-FSM encoding shared with the pupil detector
package pixel_line_capture_pkg;

    localparam int MAX_RESOLUTION = 112;
    localparam int NUM_LINES      = 112;
    localparam int PIXEL_W        = 8;
    localparam int LINE_W         = MAX_RESOLUTION * PIXEL_W;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DONE    = 2'd3
    } wr_state_e;

endpackage

// File: rtl/pixel_line_capture_line_bank.sv
// rtl/pixel_line_capture_line_bank.sv - one full-width line register with full flag and row tag
module line_bank
    import pixel_line_capture_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_idx,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               set_full,
    input  logic [CNT_W-1:0]   set_tag,
    input  logic               rd_done,
    output logic [LINE_W-1:0]  rd_line,
    output logic               full,
    output logic [CNT_W-1:0]   tag
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_line <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < MAX_RESOLUTION; k++) begin
                if (wr_idx == CNT_W'(k)) begin
                    rd_line[k*PIXEL_W +: PIXEL_W] <= wr_data;
                end
            end
        end
    end

    // set_full only targets an empty bank and rd_done only a full one, so they never collide
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            tag  <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
            tag  <= set_tag;
        end else if (rd_done) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_line_capture.sv
// rtl/pixel_line_capture.sv - packs the pixel stream into ping-pong line banks with valid/ack delivery
module pixel_line_capture
    import pixel_line_capture_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               pixel_valid,
    input  logic [PIXEL_W-1:0] pixel_data,
    output logic [LINE_W-1:0]  line_out,
    output logic               line_valid,
    input  logic               line_ack,
    output logic [CNT_W-1:0]   line_index,
    output logic               frame_capture_done,
    output logic               overflow
);

    wr_state_e         state, next_state;
    logic [CNT_W-1:0]  pixel_cnt, row_cnt, wr_idx;
    logic              wr_sel, rd_sel;
    logic [1:0]        bank_full, bank_wr_en, bank_set_full, bank_rd_done;
    logic [LINE_W-1:0] bank_line [2];
    logic [CNT_W-1:0]  bank_tag  [2];
    logic              capturing, line_end, last_row, xfer;

    assign capturing = (state == ST_FILL) || (state == ST_DISCARD);
    assign line_end  = capturing && pixel_valid && (pixel_cnt == CNT_W'(MAX_RESOLUTION - 1));
    assign last_row  = (row_cnt == CNT_W'(NUM_LINES - 1));
    assign xfer      = line_valid && line_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Banks fill strictly alternately, so wr_sel always names the next bank to write
    // and the FULL check uses the registered flag: a bank freed this edge is not yet usable.
    always_comb begin
        next_state = state;
        if (frame_start) begin
            next_state = ST_FILL;
        end else if (line_end) begin
            if (last_row)               next_state = ST_DONE;
            else if (state == ST_FILL)  next_state = bank_full[!wr_sel] ? ST_DISCARD : ST_FILL;
            else                        next_state = bank_full[wr_sel]  ? ST_DISCARD : ST_FILL;
        end
    end

    always_comb begin
        bank_wr_en    = '0;
        bank_set_full = '0;
        bank_rd_done  = '0;
        wr_idx        = pixel_cnt;
        if (frame_start) begin
            wr_idx        = '0;
            bank_wr_en[0] = pixel_valid;
        end else begin
            if (state == ST_FILL && pixel_valid) begin
                bank_wr_en[wr_sel]    = 1'b1;
                bank_set_full[wr_sel] = line_end;
            end
            if (xfer) bank_rd_done[rd_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_cnt          <= '0;
            row_cnt            <= '0;
            wr_sel             <= 1'b0;
            rd_sel             <= 1'b0;
            line_valid         <= 1'b0;
            frame_capture_done <= 1'b0;
            overflow           <= 1'b0;
        end else if (frame_start) begin
            pixel_cnt          <= pixel_valid ? CNT_W'(1) : '0;
            row_cnt            <= '0;
            wr_sel             <= 1'b0;
            rd_sel             <= 1'b0;
            line_valid         <= 1'b0;
            frame_capture_done <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            if (capturing && pixel_valid) begin
                if (line_end) begin
                    pixel_cnt <= '0;
                    row_cnt   <= row_cnt + CNT_W'(1);
                end else begin
                    pixel_cnt <= pixel_cnt + CNT_W'(1);
                end
            end
            if (state == ST_FILL && line_end) wr_sel <= !wr_sel;
            if (next_state == ST_DISCARD && state != ST_DISCARD) overflow <= 1'b1;
            if (xfer) rd_sel <= !rd_sel;
            // head of the in-order queue: after a transfer the other bank takes over
            line_valid <= xfer ? bank_full[!rd_sel] : bank_full[rd_sel];
            if (state == ST_DONE && bank_full == 2'b00) frame_capture_done <= 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank u_bank (
            .clock    (clock),
            .reset    (reset),
            .clear    (frame_start),
            .wr_en    (bank_wr_en[b]),
            .wr_idx   (wr_idx),
            .wr_data  (pixel_data),
            .set_full (bank_set_full[b]),
            .set_tag  (row_cnt),
            .rd_done  (bank_rd_done[b]),
            .rd_line  (bank_line[b]),
            .full     (bank_full[b]),
            .tag      (bank_tag[b])
        );
    end

    assign line_out   = line_valid ? bank_line[rd_sel] : '0;
    assign line_index = line_valid ? bank_tag[rd_sel]  : '0;

endmodule

// File: tb/tb_pixel_line_capture.sv
// tb/tb_pixel_line_capture.sv - directed self-checking bench for pixel_line_capture
module tb_pixel_line_capture;
    import pixel_line_capture_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic              pixel_valid = 1'b0;
    logic [7:0]        pixel_data = '0;
    logic              line_ack = 1'b0;
    logic [LINE_W-1:0] line_out;
    logic              line_valid;
    logic [7:0]        line_index;
    logic              frame_capture_done;
    logic              overflow;

    int tests_run = 0;
    int tests_failed = 0;

    int                xfer_idx [$];
    logic [LINE_W-1:0] xfer_line [$];
    int                valid_cycles = 0;

    pixel_line_capture dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .line_out(line_out), .line_valid(line_valid), .line_ack(line_ack),
        .line_index(line_index), .frame_capture_done(frame_capture_done),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && line_valid) begin
            valid_cycles++;
            if (line_ack) begin
                xfer_idx.push_back(int'(line_index));
                xfer_line.push_back(line_out);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] pix(int r, int k);
        return 8'((r * 3 + k) & 255);
    endfunction

    task automatic send_pixels(int r, int k0, int k1);
        for (int k = k0; k <= k1; k++) begin
            pixel_valid = 1'b1;
            pixel_data  = pix(r, k);
            tick();
        end
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic check(string name, longint got, longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        int v0;
        reset = 1'b0;
        tick(); tick();
        tests_run++; if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", line_valid); end
        tests_run++; if (line_out !== '0) begin tests_failed++; $display("FAIL reset_line_out: got nonzero expected 0"); end
        tests_run++; if (line_index !== 8'd0) begin tests_failed++; $display("FAIL reset_index: got %0d expected 0", line_index); end
        tests_run++; if (frame_capture_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", frame_capture_done); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b1;
        tick();
        v0 = valid_cycles;
        line_ack = 1'b1;
        send_pixels(0, 0, 111);
        tick(); tick(); tick();
        tests_run++; if (valid_cycles - v0 !== 0) begin tests_failed++; $display("FAIL idle_ignores_pixels: got %0d valid cycles expected 0", valid_cycles - v0); end
    endtask

    task automatic test_single_line();
        int n0, v0;
        line_ack = 1'b1;
        pulse_frame_start();
        n0 = xfer_idx.size();
        v0 = valid_cycles;
        send_pixels(0, 0, 111);
        tests_run++; if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL single_valid_at_N: got %b expected 0", line_valid); end
        tick();
        tests_run++; if (line_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid_at_N1: got %b expected 1", line_valid); end
        tests_run++; if (line_index !== 8'd0) begin tests_failed++; $display("FAIL single_index: got %0d expected 0", line_index); end
        tests_run++; if (line_out[7:0] !== 8'd0) begin tests_failed++; $display("FAIL single_pixel0: got %0d expected 0", line_out[7:0]); end
        tests_run++; if (line_out[895:888] !== 8'd111) begin tests_failed++; $display("FAIL single_pixel111: got %0d expected 111", line_out[895:888]); end
        tick(); tick(); tick();
        tests_run++; if (valid_cycles - v0 !== 1) begin tests_failed++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        tests_run++; if (xfer_idx.size() - n0 !== 1) begin tests_failed++; $display("FAIL single_xfers: got %0d expected 1", xfer_idx.size() - n0); end
    endtask

    task automatic test_full_frame();
        int n0;
        line_ack = 1'b1;
        pulse_frame_start();
        n0 = xfer_idx.size();
        for (int r = 0; r < NUM_LINES; r++) send_pixels(r, 0, 111);
        tick();
        tick();
        tests_run++; if (frame_capture_done !== 1'b0) begin tests_failed++; $display("FAIL frame_done_early: got %b expected 0", frame_capture_done); end
        tick();
        tests_run++; if (frame_capture_done !== 1'b1) begin tests_failed++; $display("FAIL frame_done: got %b expected 1", frame_capture_done); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL frame_overflow: got %b expected 0", overflow); end
        tests_run++;
        if (xfer_idx.size() - n0 !== NUM_LINES) begin
            tests_failed++; $display("FAIL frame_xfer_count: got %0d expected %0d", xfer_idx.size() - n0, NUM_LINES);
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tests_run++;
                if (xfer_idx[n0+i] !== i || xfer_line[n0+i][7:0] !== pix(i, 0) || xfer_line[n0+i][895:888] !== pix(i, 111)) begin
                    tests_failed++;
                    $display("FAIL frame_line_%0d: got index %0d first %0d last %0d expected index %0d first %0d last %0d",
                             i, xfer_idx[n0+i], xfer_line[n0+i][7:0], xfer_line[n0+i][895:888], i, pix(i, 0), pix(i, 111));
                end
            end
        end
    endtask

    task automatic test_overflow();
        int n0;
        line_ack = 1'b0;
        pulse_frame_start();
        n0 = xfer_idx.size();
        send_pixels(0, 0, 111);
        send_pixels(1, 0, 111);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        tests_run++; if (line_valid !== 1'b1 || line_index !== 8'd0) begin tests_failed++; $display("FAIL ovf_head: got valid %b index %0d expected valid 1 index 0", line_valid, line_index); end
        send_pixels(2, 0, 49);
        line_ack = 1'b1;
        send_pixels(2, 50, 111);
        send_pixels(3, 0, 111);
        tick(); tick(); tick();
        tests_run++;
        if (xfer_idx.size() - n0 !== 3) begin
            tests_failed++; $display("FAIL ovf_xfer_count: got %0d expected 3", xfer_idx.size() - n0);
        end else begin
            tests_run++; if (xfer_idx[n0] !== 0 || xfer_idx[n0+1] !== 1 || xfer_idx[n0+2] !== 3) begin tests_failed++; $display("FAIL ovf_indices: got %0d,%0d,%0d expected 0,1,3", xfer_idx[n0], xfer_idx[n0+1], xfer_idx[n0+2]); end
            tests_run++; if (xfer_line[n0+2][7:0] !== pix(3, 0) || xfer_line[n0+2][895:888] !== pix(3, 111)) begin tests_failed++; $display("FAIL ovf_row3_data: got %0d/%0d expected %0d/%0d", xfer_line[n0+2][7:0], xfer_line[n0+2][895:888], pix(3, 0), pix(3, 111)); end
        end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_ack_pulse();
        int n0;
        line_ack = 1'b0;
        pulse_frame_start();
        n0 = xfer_idx.size();
        send_pixels(0, 0, 111);
        send_pixels(1, 0, 111);
        send_pixels(2, 0, 110);
        tick(); tick();
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        tests_run++; if (line_valid !== 1'b1 || line_index !== 8'd1) begin tests_failed++; $display("FAIL pulse_next_head: got valid %b index %0d expected valid 1 index 1", line_valid, line_index); end
        tests_run++; if (xfer_idx.size() - n0 !== 1) begin tests_failed++; $display("FAIL pulse_one_xfer: got %0d expected 1", xfer_idx.size() - n0); end
        send_pixels(2, 111, 111);
        send_pixels(3, 0, 111);
        tests_run++; if (line_index !== 8'd1) begin tests_failed++; $display("FAIL pulse_head_stable: got %0d expected 1", line_index); end
        line_ack = 1'b1;
        tick(); tick(); tick(); tick();
        tests_run++;
        if (xfer_idx.size() - n0 !== 3) begin
            tests_failed++; $display("FAIL pulse_xfer_count: got %0d expected 3", xfer_idx.size() - n0);
        end else begin
            tests_run++; if (xfer_idx[n0+1] !== 1 || xfer_idx[n0+2] !== 3) begin tests_failed++; $display("FAIL pulse_indices: got %0d,%0d expected 1,3", xfer_idx[n0+1], xfer_idx[n0+2]); end
            tests_run++; if (xfer_line[n0+2][7:0] !== pix(3, 0) || xfer_line[n0+2][895:888] !== pix(3, 111)) begin tests_failed++; $display("FAIL pulse_row3_data: got %0d/%0d expected %0d/%0d", xfer_line[n0+2][7:0], xfer_line[n0+2][895:888], pix(3, 0), pix(3, 111)); end
        end
    endtask

    task automatic test_same_edge_free();
        int n0;
        line_ack = 1'b0;
        pulse_frame_start();
        n0 = xfer_idx.size();
        send_pixels(0, 0, 111);
        send_pixels(1, 0, 111);
        send_pixels(2, 0, 110);
        line_ack = 1'b1;
        send_pixels(2, 111, 111);
        line_ack = 1'b0;
        send_pixels(3, 0, 111);
        line_ack = 1'b1;
        tick(); tick(); tick(); tick();
        tests_run++; if (xfer_idx.size() - n0 !== 2) begin tests_failed++; $display("FAIL same_edge_xfer_count: got %0d expected 2", xfer_idx.size() - n0); end
    endtask

    task automatic test_abort();
        int n0;
        line_ack = 1'b1;
        pulse_frame_start();
        send_pixels(0, 0, 111);
        send_pixels(1, 0, 111);
        send_pixels(2, 0, 111);
        tick(); tick(); tick();
        line_ack = 1'b0;
        send_pixels(3, 0, 111);
        send_pixels(4, 0, 111);
        send_pixels(5, 0, 49);
        tests_run++; if (overflow !== 1'b1 || line_valid !== 1'b1) begin tests_failed++; $display("FAIL abort_pre: got overflow %b valid %b expected 1 1", overflow, line_valid); end
        n0 = xfer_idx.size();
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = 8'hAB;
        tick();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        tests_run++; if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_valid: got %b expected 0", line_valid); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL abort_overflow: got %b expected 0", overflow); end
        line_ack = 1'b1;
        send_pixels(0, 1, 111);
        tick(); tick(); tick();
        tests_run++;
        if (xfer_idx.size() - n0 !== 1) begin
            tests_failed++; $display("FAIL abort_xfer_count: got %0d expected 1", xfer_idx.size() - n0);
        end else begin
            tests_run++; if (xfer_idx[n0] !== 0) begin tests_failed++; $display("FAIL abort_index: got %0d expected 0", xfer_idx[n0]); end
            tests_run++; if (xfer_line[n0][7:0] !== 8'hAB || xfer_line[n0][895:888] !== pix(0, 111)) begin tests_failed++; $display("FAIL abort_data: got %0d/%0d expected 171/%0d", xfer_line[n0][7:0], xfer_line[n0][895:888], pix(0, 111)); end
        end
    endtask

    task automatic test_async_reset();
        int n0, v0;
        line_ack = 1'b0;
        pulse_frame_start();
        send_pixels(0, 0, 111);
        send_pixels(1, 0, 29);
        tests_run++; if (line_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_valid: got %b expected 1", line_valid); end
        #2;
        reset = 1'b0;
        #1;
        tests_run++; if (line_valid !== 1'b0 || line_index !== 8'd0 || line_out !== '0) begin tests_failed++; $display("FAIL areset_outputs: got valid %b index %0d expected 0 0", line_valid, line_index); end
        tests_run++; if (overflow !== 1'b0 || frame_capture_done !== 1'b0) begin tests_failed++; $display("FAIL areset_flags: got overflow %b done %b expected 0 0", overflow, frame_capture_done); end
        tick();
        reset = 1'b1;
        tick();
        n0 = xfer_idx.size();
        v0 = valid_cycles;
        line_ack = 1'b1;
        send_pixels(0, 0, 111);
        tick(); tick(); tick();
        tests_run++; if (valid_cycles - v0 !== 0) begin tests_failed++; $display("FAIL areset_ignores_pixels: got %0d valid cycles expected 0", valid_cycles - v0); end
        pulse_frame_start();
        send_pixels(9, 0, 111);
        tick(); tick(); tick();
        tests_run++; if (xfer_idx.size() - n0 !== 1) begin tests_failed++; $display("FAIL areset_restart: got %0d xfers expected 1", xfer_idx.size() - n0); end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_full_frame();
        test_overflow();
        test_ack_pulse();
        test_same_edge_free();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
